// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage, driving the mul/div stall request.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle product.
module ex_muldiv_unit #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);
    localparam int PW = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [2:0]      op_q;
    logic            is_word_q;
    logic            is_div_q;
    logic            neg_q;
    logic            neg_r_q;
    logic [6:0]      cnt_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] divisor_q;

    logic [2:0]      op_n;
    logic            is_div;
    logic            sx1, sx2, abs1, abs2;
    logic [XLEN-1:0] op1, op2, mag1, mag2, min_val;
    logic            n1, n2;
    logic            div_zero, div_ovf, one_cycle, start_ok;

    logic [XLEN:0]   rem_shift, rem_diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step;

    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, sel, res_word;

`ifdef MULDIV_FAST_MUL_EN
    logic [PW-1:0]   fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

    // Operand decode: W extension, magnitudes and the single-cycle special cases
    always_comb begin
        op_n   = (|op_i[OP_W-1:3]) ? OP_MUL : op_i[2:0];
        is_div = op_n[2];
        sx1    = 1'b1;
        sx2    = 1'b1;
        abs1   = 1'b0;
        abs2   = 1'b0;
        case (op_n)
            OP_MULH, OP_DIV, OP_REM: begin
                abs1 = 1'b1;
                abs2 = 1'b1;
            end
            OP_MULHSU: begin
                abs1 = 1'b1;
                sx2  = 1'b0;
            end
            OP_MULHU, OP_DIVU, OP_REMU: begin
                sx1 = 1'b0;
                sx2 = 1'b0;
            end
            default: ;
        endcase
        op1 = rs1_i;
        op2 = rs2_i;
        if (is_word_i) begin
            op1 = {{(XLEN-32){sx1 & rs1_i[31]}}, rs1_i[31:0]};
            op2 = {{(XLEN-32){sx2 & rs2_i[31]}}, rs2_i[31:0]};
        end
        n1       = abs1 & op1[XLEN-1];
        n2       = abs2 & op2[XLEN-1];
        mag1     = n1 ? -op1 : op1;
        mag2     = n2 ? -op2 : op2;
        min_val  = is_word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (op2 == '0);
        div_ovf  = is_div & abs1 & (op1 == min_val) & (op2 == '1);
        one_cycle = div_zero | div_ovf;
`ifdef MULDIV_FAST_MUL_EN
        one_cycle = one_cycle | ~is_div;
`endif
        start_ok = start_i & ~flush_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = one_cycle ? DONE : BUSY;
            BUSY:    if (cnt_q == 7'd1) state_next = DONE;
            DONE:    if (!ex_stall_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
        q_bit     = ~rem_diff[XLEN];
        rem_step  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            is_word_q <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else if (state == IDLE && start_ok) begin
            op_q      <= op_n;
            is_word_q <= is_word_i;
            is_div_q  <= is_div;
            neg_q     <= n1 ^ n2;
            neg_r_q   <= n1;
            cnt_q     <= is_word_i ? 7'd32 : 7'(XLEN);
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, mag1};
            mplier_q  <= mag2;
            // W dividends are pre-aligned so the top bit is always the next one to shift in
            quot_q    <= is_word_i ? (mag1 << 32) : mag1;
            rem_q     <= '0;
            divisor_q <= mag2;
            if (div_zero) begin
                quot_q  <= '1;
                rem_q   <= op1;
                neg_q   <= 1'b0;
                neg_r_q <= 1'b0;
            end else if (div_ovf) begin
                quot_q  <= op1;
                rem_q   <= '0;
                neg_q   <= 1'b0;
                neg_r_q <= 1'b0;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
                acc_q <= fast_prod;
            end
`endif
        end else if (state == BUSY) begin
            cnt_q <= cnt_q - 7'd1;
            if (is_div_q) begin
                rem_q  <= rem_step;
                quot_q <= {quot_q[XLEN-2:0], q_bit};
            end else begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -quot_q : quot_q;
        rem_fix  = neg_r_q ? -rem_q : rem_q;
        case (op_q)
            OP_MUL:                      sel = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod_fix[PW-1:XLEN];
            OP_DIV, OP_DIVU:             sel = quot_fix;
            default:                     sel = rem_fix;
        endcase
        res_word = is_word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    always_comb begin
        stall_req_o    = 1'b0;
        busy_o         = 1'b0;
        result_o       = '0;
        result_valid_o = 1'b0;
        if (!rst) begin
            busy_o = (state != IDLE);
            case (state)
                IDLE: stall_req_o = start_ok;
                BUSY: stall_req_o = ~flush_i;
                DONE: begin
                    result_o       = res_word;
                    result_valid_o = ~flush_i;
                end
                default: ;
            endcase
        end
    end
endmodule
